// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the execute stage.
//   - ALU-op encodings coming from decode.
//   - R-type funct codes carried in sign_ext[5:0].
//   - Internal ALU-select enum, produced once by decode_sel().
//   - IDLE/MUL state enum for the stage sequencer.
// -----------------------------------------------------------------------------
package ex_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_SUB = 6'd1;
    localparam logic [5:0] FN_MUL = 6'd2;
    localparam logic [5:0] FN_AND = 6'd3;
    localparam logic [5:0] FN_OR  = 6'd4;
    localparam logic [5:0] FN_SLT = 6'd5;

    typedef enum logic [2:0] {
        SEL_ADD,
        SEL_SUB,
        SEL_MUL,
        SEL_AND,
        SEL_OR,
        SEL_SLT,
        SEL_ILL
    } alu_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

    // Collapse alu_op + funct into one select; everything unknown is illegal.
    function automatic alu_sel_e decode_sel(input logic [1:0] op, input logic [5:0] fn);
        alu_sel_e sel;
        sel = SEL_ILL;
        case (op)
            OP_ADD: sel = SEL_ADD;
            OP_SUB: sel = SEL_SUB;
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  sel = SEL_ADD;
                    FN_SUB:  sel = SEL_SUB;
                    FN_MUL:  sel = SEL_MUL;
                    FN_AND:  sel = SEL_AND;
                    FN_OR:   sel = SEL_OR;
                    FN_SLT:  sel = SEL_SLT;
                    default: sel = SEL_ILL;
                endcase
            end
            default: sel = SEL_ILL;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// -----------------------------------------------------------------------------
// ex_mul_seq
// Radix-2 shift-add multiplier, one partial product per cycle, XLEN steps.
// Returns the low XLEN bits of the unsigned product.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   start_i          capture a_i/b_i and begin (ignored while abort_i)
//   abort_i          drop the operation in progress
//   a_i, b_i         operands
//   done_o           high during the cycle of the last step
//   product_o        valid while done_o is high (includes the last step)
// -----------------------------------------------------------------------------
module ex_mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    // The final step is exposed combinationally so the caller can register
    // the product on the same edge the last partial product is added.
    assign done_o    = busy_q & (cnt_q == LAST);
    assign product_o = acc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_pipe_unit.sv
// -----------------------------------------------------------------------------
// ex_pipe_unit
// Handshaked execute stage: ALU, zero flag, branch resolution, and a
// multi-cycle multiplier behind a valid/ready interface with flush.
// Ports:
//   clk_i, reset_ni              clock, async active-low reset
//   flush_i                      kill held/in-flight instruction, drop input
//   in_valid_i / in_ready_o      upstream handshake
//   pc_i, rs_i, rt_i, sign_ext_i instruction operands (sign_ext[5:0] = funct)
//   alu_src_i, alu_op_i, branch_i decode controls
//   out_valid_o / out_ready_i    downstream handshake
//   result_o, zero_o, br_taken_o, br_target_o, illegal_o  registered results
// -----------------------------------------------------------------------------
module ex_pipe_unit
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [PC_W-1:0] pc_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic [XLEN-1:0] sign_ext_i,
    input  logic            alu_src_i,
    input  logic [1:0]      alu_op_i,
    input  logic            branch_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            br_taken_o,
    output logic [PC_W-1:0] br_target_o,
    output logic            illegal_o
);

    state_e          state_q, state_d;
    alu_sel_e        sel;
    logic [XLEN-1:0] op2, alu_res;
    logic            zero_c, br_taken_c;
    logic [PC_W-1:0] offs, tgt_c;
    logic            accept, start_mul, load_alu, load_mul;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q;
    logic            zero_q, br_taken_q, illegal_q;
    logic [PC_W-1:0] br_target_q;
    // Branch info of the instruction sitting in the multiplier.
    logic            pend_zero_q, pend_bt_q;
    logic [PC_W-1:0] pend_tgt_q;

    assign op2        = alu_src_i ? sign_ext_i : rt_i;
    assign sel        = decode_sel(alu_op_i, sign_ext_i[5:0]);
    assign zero_c     = (rs_i == op2);
    assign br_taken_c = branch_i & zero_c;

    // Fit the immediate to PC width (sign-extend if narrower) before scaling.
    generate
        if (XLEN >= PC_W) begin : g_offs_trunc
            assign offs = sign_ext_i[PC_W-1:0];
        end else begin : g_offs_sext
            assign offs = {{(PC_W-XLEN){sign_ext_i[XLEN-1]}}, sign_ext_i};
        end
    endgenerate
    assign tgt_c = pc_i + (offs << 2);

    always_comb begin
        alu_res = '0;
        case (sel)
            SEL_ADD: alu_res = rs_i + op2;
            SEL_SUB: alu_res = rs_i - op2;
            SEL_AND: alu_res = rs_i & op2;
            SEL_OR:  alu_res = rs_i | op2;
            SEL_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs_i) < $signed(op2))};
            default: alu_res = '0;
        endcase
    end

    assign in_ready_o = (state_q == ST_IDLE) & (~out_valid_q | out_ready_i);
    // Flush wins over a simultaneous accept.
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign start_mul  = accept & (sel == SEL_MUL);
    assign load_alu   = accept & (sel != SEL_MUL);
    assign load_mul   = (state_q == ST_MUL) & mul_done & ~flush_i;

    ex_mul_seq #(.XLEN(XLEN)) u_mul (
        .clk_i     (clk_i),
        .rst_ni    (reset_ni),
        .start_i   (start_mul),
        .abort_i   (flush_i),
        .a_i       (rs_i),
        .b_i       (op2),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_mul) state_d = ST_MUL;
            ST_MUL:  if (flush_i || mul_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A take and a new load on the same edge keep out_valid high (no bubble).
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush_i)                   out_valid_d = 1'b0;
        else if (load_alu || load_mul) out_valid_d = 1'b1;
        else if (out_ready_i)          out_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            illegal_q   <= 1'b0;
            pend_zero_q <= 1'b0;
            pend_bt_q   <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (start_mul) begin
                pend_zero_q <= zero_c;
                pend_bt_q   <= br_taken_c;
                pend_tgt_q  <= tgt_c;
            end
            if (load_alu) begin
                result_q    <= alu_res;
                zero_q      <= zero_c;
                br_taken_q  <= br_taken_c;
                br_target_q <= tgt_c;
                illegal_q   <= (sel == SEL_ILL);
            end else if (load_mul) begin
                result_q    <= mul_prod;
                zero_q      <= pend_zero_q;
                br_taken_q  <= pend_bt_q;
                br_target_q <= pend_tgt_q;
                illegal_q   <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign br_taken_o  = br_taken_q;
    assign br_target_o = br_target_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_ex_pipe_unit.sv
// -----------------------------------------------------------------------------
// tb_ex_pipe_unit
// Transaction-level reference model of the execute stage plus directed and
// randomized stimulus. The model tracks: is an output held, what it is, and
// how many multiply cycles remain; expected values come from plain arithmetic.
// -----------------------------------------------------------------------------
module tb_ex_pipe_unit;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush, in_valid, in_ready;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] rs, rt, sign_ext;
    logic            alu_src, branch;
    logic [1:0]      alu_op;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] result;
    logic            zero, br_taken, illegal;
    logic [PC_W-1:0] br_target;

    ex_pipe_unit #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk_i(clk), .reset_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .rs_i(rs), .rt_i(rt), .sign_ext_i(sign_ext),
        .alu_src_i(alu_src), .alu_op_i(alu_op), .branch_i(branch),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .zero_o(zero), .br_taken_o(br_taken),
        .br_target_o(br_target), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    // Reference model state.
    bit              m_valid;
    int              m_busy;          // multiply cycles still to run
    logic [XLEN-1:0] m_res;
    bit              m_zero, m_bt, m_ill;
    logic [PC_W-1:0] m_tgt;
    logic [XLEN-1:0] p_res;           // multiply instruction waiting to finish
    bit              p_zero, p_bt;
    logic [PC_W-1:0] p_tgt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_busy = 0; m_res = '0; m_zero = 0; m_bt = 0; m_ill = 0; m_tgt = '0;
    endtask

    function automatic bit exp_ready();
        return (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    // What the instruction on the inputs must produce.
    task automatic golden(output logic [XLEN-1:0] r, output bit z, output bit bt,
                          output logic [PC_W-1:0] t, output bit ill, output bit is_mul);
        logic [XLEN-1:0] b;
        b = alu_src ? sign_ext : rt;
        z = (rs == b);
        bt = branch && z;
        t = pc + (sign_ext << 2);
        ill = 0; is_mul = 0; r = '0;
        case (alu_op)
            2'd0: r = rs + b;
            2'd1: r = rs - b;
            2'd2: case (sign_ext[5:0])
                6'd0: r = rs + b;
                6'd1: r = rs - b;
                6'd2: begin is_mul = 1; r = rs * b; end
                6'd3: r = rs & b;
                6'd4: r = rs | b;
                6'd5: r = ($signed(rs) < $signed(b)) ? 1 : 0;
                default: ill = 1;
            endcase
            default: ill = 1;
        endcase
    endtask

    // Advance the model by one clock edge with the inputs currently applied.
    task automatic model_step();
        logic [XLEN-1:0] r; bit z, bt, ill, mul; logic [PC_W-1:0] t;
        bit acc;
        if (!rst_n) begin model_reset(); return; end
        acc = in_valid && exp_ready();
        if (flush) begin
            m_valid = 0; m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1; m_res = p_res; m_zero = p_zero; m_bt = p_bt;
                m_tgt = p_tgt; m_ill = 0;
            end
        end else begin
            if (m_valid && out_ready) m_valid = 0;
            if (acc) begin
                golden(r, z, bt, t, ill, mul);
                if (mul) begin
                    m_busy = XLEN; p_res = r; p_zero = z; p_bt = bt; p_tgt = t;
                end else begin
                    m_valid = 1; m_res = r; m_zero = z; m_bt = bt; m_tgt = t; m_ill = ill;
                end
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", 64'(in_ready), 64'(exp_ready()));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("result", 64'(result), 64'(m_res));
            chk("zero", 64'(zero), 64'(m_zero));
            chk("br_taken", 64'(br_taken), 64'(m_bt));
            chk("br_target", 64'(br_target), 64'(m_tgt));
            chk("illegal", 64'(illegal), 64'(m_ill));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic instr(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] imm, input logic src, input logic br,
                         input logic [PC_W-1:0] p);
        in_valid = 1; alu_op = op; rs = a; rt = b; sign_ext = imm;
        alu_src = src; branch = br; pc = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
        pc = '0; rs = '0; rt = '0; sign_ext = '0; alu_src = 0; alu_op = 0; branch = 0;
        model_reset();
        repeat (3) cyc();
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_br_target", 64'(br_target), 64'd0);
        chk("rst_flags", {61'd0, zero, br_taken, illegal}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1;
        cyc();

        // add 5+7
        instr(2'b10, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("add_lit_valid", 64'(out_valid), 64'd1);
        chk("add_lit_res", 64'(result), 64'd12);
        chk("add_lit_zero", 64'(zero), 64'd0);

        // beq taken
        instr(2'b01, 32'd9, 32'd9, 32'd4, 1'b0, 1'b1, 32'h100);
        cyc();
        chk("beq_lit_res", 64'(result), 64'd0);
        chk("beq_lit_flags", {62'd0, zero, br_taken}, 64'd3);
        chk("beq_lit_tgt", 64'(br_target), 64'h110);

        // mul 6*7 with backpressure
        instr(2'b10, 32'd6, 32'd7, 32'd2, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 0; out_ready = 0;
        for (int i = 0; i < XLEN; i++) begin
            if (i < XLEN - 1) chk("mul_lit_busy", 64'(in_ready), 64'd0);
            cyc();
        end
        chk("mul_lit_valid", 64'(out_valid), 64'd1);
        chk("mul_lit_res", 64'(result), 64'd42);
        repeat (3) cyc();
        chk("mul_lit_hold", 64'(result), 64'd42);
        out_ready = 1;
        cyc();

        // flush mid-multiply
        instr(2'b10, 32'd3, 32'd5, 32'd2, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 0;
        repeat (9) cyc();
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_lit_ready", 64'(in_ready), 64'd1);
        chk("flush_lit_valid", 64'(out_valid), 64'd0);
        instr(2'b00, 32'd1, 32'd0, 32'd1, 1'b1, 1'b0, 32'h0);
        cyc();
        chk("flush_lit_add", 64'(result), 64'd2);
        in_valid = 0;
        repeat (XLEN + 2) cyc();

        // illegal funct
        instr(2'b10, 32'd3, 32'd4, 32'h3f, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("ill_lit", {31'd0, illegal, result}, {31'd0, 1'b1, 32'd0});

        // hold a result, then async reset without a clock edge
        instr(2'b00, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1, 32'h40);
        cyc();
        in_valid = 0; out_ready = 0;
        cyc();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_result", 64'(result), 64'd0);
        chk("async_tgt", 64'(br_target), 64'd0);
        chk("async_flags", {61'd0, zero, br_taken, illegal}, 64'd0);
        cyc();
        rst_n = 1; out_ready = 1;
        cyc();

        // reset mid-multiply: partial product discarded
        instr(2'b10, 32'd11, 32'd13, 32'd2, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 0;
        repeat (5) cyc();
        rst_n = 0;
        cyc();
        rst_n = 1;
        repeat (XLEN + 4) cyc();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [5:0] fn;
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 5));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            alu_op    = 2'($urandom_range(0, 3));
            alu_src   = $urandom_range(0, 1);
            branch    = $urandom_range(0, 1);
            rs        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rt        = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            sign_ext  = {26'($urandom), fn};
            pc        = $urandom;
            cyc();
        end
        flush = 0; in_valid = 0; out_ready = 1;
        repeat (XLEN + 2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/ex_pipe_unit.md
# ex_pipe_unit

Parametrised, handshaked execute stage: takes one decoded instruction per transaction (operands, immediate, ALU op, branch flag, PC) and produces a registered ALU result, a zero flag and a resolved branch target. It sits between the decode and memory stages. It replaces the fixed 32-bit single-cycle execute path with three additions: configurable width, a multi-cycle sequential multiplier, and valid/ready backpressure with flush.

## Interface
- XLEN, 32: datapath width (≥8).
- PC_W, 32: program-counter width.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- flush  in  1  synchronous kill of in-flight/held instruction.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  stage can accept this cycle.
- pc  in  PC_W  instruction PC.
- rs, rt  in  XLEN  register operands.
- sign_ext  in  XLEN  sign-extended immediate; [5:0] is funct for R-type.
- alu_src  in  1  0: op2=rt, 1: op2=sign_ext.
- alu_op  in  2  00 add, 01 sub (BEQ), 10 R-type via funct, 11 illegal.
- branch  in  1  instruction is BEQ.
- out_valid  out  1  result registers hold a valid instruction.
- out_ready  in  1  downstream accepts.
- result  out  XLEN  ALU result.
- zero  out  1  rs == op2.
- br_taken  out  1  branch & zero.
- br_target  out  PC_W  pc + (sign_ext << 2), truncated to PC_W.
- illegal  out  1  alu_op 11 or unknown funct.

## Operation
- funct: 000000 ADD, 000001 SUB, 000010 MUL, 000011 AND, 000100 OR, 000101 SLT (signed, result 1/0). Any other funct → illegal=1, result=0.
- Load/store address: alu_op 00 with alu_src=1 gives rs + sign_ext (byte offset, no shift).
- Arithmetic is modulo 2^XLEN; MUL returns the low XLEN bits of the unsigned product.
- zero and br_target are computed for every instruction; br_taken asserts only when branch=1.
- FSM states: IDLE, MUL.
  - IDLE + accept of a non-MUL instruction: result registers load, out_valid=1, stay IDLE.
  - IDLE + accept of MUL: capture operands, go to MUL, counter=0.
  - MUL: one shift-add step per cycle; after XLEN steps, load the result registers, set out_valid=1, return to IDLE.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- Accept = in_valid & in_ready.
- Output hold: while out_valid & !out_ready, all outputs remain stable.
- flush: clears out_valid, aborts MUL (→IDLE), and drops any input presented that cycle. flush beats a simultaneous accept.

## Timing
- Reset values: out_valid=0, result=0, zero=0, br_taken=0, br_target=0, illegal=0, state=IDLE. in_ready reads 1.
- Non-MUL latency: accept at edge N → out_valid high after edge N, so outputs are visible in cycle N+1.
- Throughput: one instruction per cycle when out_ready stays high.
- MUL latency: accept at edge N → out_valid after edge N+XLEN. in_ready=0 for those XLEN cycles.
- Reset asserted mid-MUL: the partial product is discarded and no output is produced.
- A downstream take (out_valid & out_ready) and a new accept on the same edge are legal: the new result replaces the old one with no bubble.

## Structure
- Shared package ex_pkg holds:
  - alu_op encodings;
  - funct constants;
  - the internal ALU-select enum;
  - the IDLE/MUL state enum.
- Sub-module ex_mul_seq (XLEN): start/done, radix-2 shift-add over XLEN cycles, abort input driven by flush.

## Test plan
- add: rs=5, rt=7, alu_op=10, funct=000000, out_ready=1 → next cycle out_valid=1, result=12, zero=0, illegal=0.
- beq taken: rs=rt=9, alu_op=01, branch=1, pc=0x100, sign_ext=4 → result=0, zero=1, br_taken=1, br_target=0x110.
- mul with backpressure: rs=6, rt=7, MUL, out_ready=0 → in_ready low 32 cycles; out_valid after edge N+32, result=42; output held stable until out_ready=1.
- flush mid-MUL: flush at cycle N+10 → out_valid stays 0, in_ready=1 next cycle, and a following ADD 1+1 returns 2.
- illegal plus async reset: funct=111111 → illegal=1, result=0. reset pulsed low while out_valid=1 → all outputs 0 immediately, without waiting for a clock edge.
